// File: rtl/bram_fifo.sv
// Single-clock FIFO on a block-RAM array with a registered read port and fill-level flags.
// Define BRAM_FIFO_ERR_FLAGS_EN to add the sticky overflow/underflow outputs.
module bram_fifo #(
    parameter int unsigned DATA_WIDTH    = 18,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned AFULL_THRESH  = DEPTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      rd_en,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [$clog2(DEPTH):0]    count
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                      overflow,
    output logic                      underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q, dout_valid_d;
    logic                  wr_acc, rd_acc;

    // Flags come straight from the registered count, so they lag the access by one cycle.
    assign full         = (count_q == DepthC);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfullC);
    assign almost_empty = (count_q <= AemptyC);
    assign count        = count_q;
    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;

    // No read-through: an empty FIFO never accepts a read, so a full FIFO can only
    // accept a write when the simultaneous read frees a slot.
    always_comb begin
        rd_acc = rd_en && !empty && !flush;
        wr_acc = wr_en && (!full || rd_acc) && !flush;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_valid_d = rd_acc;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_valid_q <= dout_valid_d;
            if (rd_acc) dout_q <= mem[rd_ptr_q];
        end
    end

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow_d  = 1'b1;
            if (rd_en && empty)   underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_bram_fifo.sv
// Randomized bench for bram_fifo (DEPTH=16) against a queue-based reference model.
module tb_bram_fifo;

    localparam int DW    = 18;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [4:0]    count;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    bram_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // Reference model state
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_dout;
    bit            exp_valid;
    bit            exp_ovf;
    bit            exp_unf;
    int            n_checks;
    int            n_errors;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check_eq("dout_valid", 32'(dout_valid), 32'(exp_valid));
        check_eq("dout", 32'(dout), 32'(exp_dout));
`ifdef BRAM_FIFO_ERR_FLAGS_EN
        check_eq("overflow", 32'(overflow), 32'(exp_ovf));
        check_eq("underflow", 32'(underflow), 32'(exp_unf));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    // Drive one clock of stimulus, then advance the model and compare just after the edge.
    task automatic cycle(input bit w, input bit r, input bit f, input logic [DW-1:0] d);
        int n;
        bit rd_ok;
        bit wr_ok;
        wr_en = w;
        rd_en = r;
        flush = f;
        din   = d;
        @(posedge clk);
        #1;
        n = q.size();
        if (f) begin
            q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            rd_ok = r && (n > 0);
            wr_ok = w && ((n < DEPTH) || rd_ok);
            if (w && !wr_ok) exp_ovf = 1'b1;
            if (r && n == 0) exp_unf = 1'b1;
            exp_valid = rd_ok;
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return DW'($urandom);
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Fill 1..16 in order, then drain
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Simultaneous access while full, then while empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b1, 1'b0, 18'h2AAAA);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Overflow on full, underflow on empty
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b0, 1'b0, rnd_word());
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Steady occupancy of 5 across several pointer wraps
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0, rnd_word());
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Flush with 8 entries stored and both requests high
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b1, 1'b1, 1'b1, rnd_word());
        cycle(1'b0, 1'b0, 1'b0, '0);

        // Random traffic: write-heavy then read-heavy, rare flushes
        for (int i = 0; i < 400; i++) begin
            int wb;
            wb = (i < 200) ? 70 : 35;
            cycle(($urandom_range(99) < wb), ($urandom_range(99) < 50),
                  ($urandom_range(99) < 2), rnd_word());
        end

        // Asynchronous reset in the middle of a read cycle
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        cycle(1'b0, 1'b1, 1'b0, '0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        rd_en = 1'b0;
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, rnd_word());
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bram_fifo.md
BRAM_FIFO -- requirements
Module: bram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18: width of each stored word.
REQ-002 SHALL have parameter DEPTH, default 1024: number of entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4: almost_full asserts at or above this fill count.
REQ-004 SHALL have parameter AEMPTY_THRESH, default 4: almost_empty asserts at or below this fill count.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port flush, input, 1: synchronous clear of all contents.
REQ-008 SHALL have port wr_en, input, 1: write request.
REQ-009 SHALL have port din, input, DATA_WIDTH: write data.
REQ-010 SHALL have port rd_en, input, 1: read request.
REQ-011 SHALL have port dout, output, DATA_WIDTH: read data.
REQ-012 SHALL have port dout_valid, output, 1: dout carries a newly read word this cycle.
REQ-013 SHALL have port full, output, 1: count == DEPTH.
REQ-014 SHALL have port empty, output, 1: count == 0.
REQ-015 SHALL have port almost_full, output, 1: count >= AFULL_THRESH.
REQ-016 SHALL have port almost_empty, output, 1: count <= AEMPTY_THRESH.
REQ-017 SHALL have port count, output, clog2(DEPTH)+1: number of stored entries, 0..DEPTH.

Function
REQ-018 SHALL store data in a block-RAM-inferred array with registered read; array contents are not reset.
REQ-019 SHALL accept a write when wr_en=1 and (full=0 or an accepted read occurs in the same cycle); din goes to wr_ptr, wr_ptr increments.
REQ-020 SHALL accept a read when rd_en=1 and empty=0; the word at rd_ptr is presented on dout one cycle later with dout_valid=1 for exactly that cycle; rd_ptr increments.
REQ-021 SHALL hold dout at its last value when no read is accepted; dout_valid=0 in that case.
REQ-022 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0.
REQ-023 SHALL update count +1 on write only, -1 on read only, unchanged on both or neither; count never exceeds DEPTH or goes below 0.
REQ-024 SHALL, when empty and wr_en=rd_en=1, accept the write only; the read is ignored (no read-through).
REQ-025 SHALL, when full and wr_en=rd_en=1, accept both; count stays DEPTH.
REQ-026 SHALL derive full, empty, almost_full and almost_empty from the registered count, valid the cycle after the causing access.
REQ-027 SHALL, on flush=1, set wr_ptr, rd_ptr and count to 0 and dout_valid to 0 next cycle, ignoring wr_en and rd_en that cycle; dout holds its value.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 SHALL abandon any read in flight at reset; release of rst_n resumes operation on the next rising clk edge.

Configuration
REQ-030 SHALL, when BRAM_FIFO_ERR_FLAGS_EN is defined, add outputs overflow and underflow (1 bit each), sticky-set by a rejected write (REQ-019) or a rejected read (rd_en=1 while empty=1, including REQ-024), cleared only by reset or flush.
REQ-031 SHALL, when BRAM_FIFO_ERR_FLAGS_EN is undefined, omit both ports and their logic; rejected accesses are silently dropped.

Verification (DATA_WIDTH=18, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4)
REQ-032 SHALL cover: reset, write 0x00001..0x00010 one per cycle -> full=1 after 16th write, count=16, almost_full from count 12; then 16 reads -> dout 0x00001..0x00010 in order, each one cycle after its rd_en, empty=1.
REQ-033 SHALL cover: 40 writes interleaved with 40 reads, occupancy kept at 5 -> pointers wrap at least twice, data order preserved, count stays 5 after warm-up.
REQ-034 SHALL cover: full, wr_en=rd_en=1 with din=0x2AAAA -> count stays 16, 0x2AAAA read out as 17th word; empty, wr_en=rd_en=1 -> count=1, dout_valid=0.
REQ-035 SHALL cover: write to full FIFO with rd_en=0 -> count=16, word discarded, overflow=1 if BRAM_FIFO_ERR_FLAGS_EN; read from empty FIFO -> dout_valid=0, underflow=1 if enabled.
REQ-036 SHALL cover: 8 entries stored, flush with wr_en=rd_en=1 -> next cycle count=0, empty=1, dout_valid=0, sticky flags cleared.
REQ-037 SHALL cover: rst_n pulled low mid-cycle during a read -> outputs reach reset values before next clk edge, no dout_valid afterwards.
